// File: rtl/dp_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the dot-product sequencer.
// Holds the FSM encoding, the integer helpers and the pipeline drain length.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Operand register + multiplier + adder input register + adder + sum register.
    function automatic int drain_cycles(input int fpm_delay, input int fpa_delay);
        return fpm_delay + fpa_delay + 4;
    endfunction

endpackage

// File: rtl/dp_seq_counter.sv
// Loadable down-counter with zero flag, shared by the FEED and DRAIN phases.
// Load wins over decrement; decrementing at zero holds at zero.
module dp_seq_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dot_product_sequencer.sv
// Runs one dot product per start: clear, N_FEED operand beats, pipeline drain, hold result.
// Result valid 2+N_FEED+DRAIN cycles after start; held on res_valid until res_ready, abort cancels.
module dot_product_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int PIXEL_N   = 10,
    parameter int PARALLEL  = 2,
    parameter int FPM_DELAY = 6,
    parameter int FPA_DELAY = 2,
    parameter int VAL_SIZE  = 26,
    parameter int ADDR_W    = 8
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                abort,
    output logic                feed_valid,
    output logic [ADDR_W-1:0]   feed_addr,
    output logic [PARALLEL-1:0] feed_mask,
    output logic                dp_clear,
    input  logic [VAL_SIZE-1:0] dp_value,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [VAL_SIZE-1:0] res_data,
    output logic                busy
);

    localparam int N_FEED = ceil_div(PIXEL_N, PARALLEL);
    localparam int REM    = PIXEL_N - (N_FEED - 1) * PARALLEL;
    localparam int DRAIN  = drain_cycles(FPM_DELAY, FPA_DELAY);
    localparam int CNT_W  = clog2(max2(N_FEED, DRAIN)) + 1;

    localparam logic [CNT_W-1:0]    FEED_LOAD = CNT_W'(N_FEED - 1);
    localparam logic [CNT_W-1:0]    DRAIN_LOAD = CNT_W'(DRAIN - 1);
    localparam logic [PARALLEL-1:0] FULL_MASK = '1;
    localparam logic [PARALLEL-1:0] LAST_MASK = FULL_MASK >> (PARALLEL - REM);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [VAL_SIZE-1:0] res_q, res_d;
    logic                abort_clr_q, abort_clr_d;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_load_val;
    logic                cnt_dec;
    logic                cnt_zero;

    dp_seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (GlobalReset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        res_d        = res_q;
        abort_clr_d  = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        // Abort outranks everything else; the datapath gets a clear the cycle after.
        if ((state_q != ST_IDLE) && abort) begin
            state_d     = ST_IDLE;
            abort_clr_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        addr_d  = base_addr;
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = FEED_LOAD;
                    state_d      = ST_FEED;
                end
                ST_FEED: begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_LOAD;
                        state_d      = ST_DRAIN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_zero) begin
                        res_d   = dp_value;
                        state_d = ST_DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            res_q       <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            res_q       <= res_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign feed_valid  = (state_q == ST_FEED);
    assign feed_addr   = addr_q;
    assign feed_mask   = (state_q != ST_FEED) ? '0 : (cnt_zero ? LAST_MASK : FULL_MASK);
    assign dp_clear    = (state_q == ST_CLEAR) || abort_clr_q;
    assign res_valid   = (state_q == ST_DONE);
    assign res_data    = res_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized bench for two sequencer configurations (PIXEL_N 10 and 9) sharing one stimulus stream.
module tb_dot_product_sequencer;

    localparam int NF     = 5;                 // ceil(10/2) and ceil(9/2)
    localparam int DRN    = 6 + 2 + 4;
    localparam int DONE_K = 2 + NF + DRN;      // first res_valid cycle after start cycle 0

    logic        clk = 1'b0;
    logic        GlobalReset;
    logic        start_valid;
    logic [7:0]  base_addr;
    logic        abort;
    logic [25:0] dp_value;
    logic        res_ready;

    logic        a_start_ready, a_feed_valid, a_dp_clear, a_res_valid, a_busy;
    logic [7:0]  a_feed_addr;
    logic [1:0]  a_feed_mask;
    logic [25:0] a_res_data;
    logic        b_start_ready, b_feed_valid, b_dp_clear, b_res_valid, b_busy;
    logic [7:0]  b_feed_addr;
    logic [1:0]  b_feed_mask;
    logic [25:0] b_res_data;

    int          checks = 0;
    int          failures = 0;
    logic [25:0] exp_res;
    int          op_id = 0;

    always #5 clk = ~clk;

    dot_product_sequencer #(.PIXEL_N(10)) dut_a (
        .clk(clk), .GlobalReset(GlobalReset), .start_valid(start_valid), .start_ready(a_start_ready),
        .base_addr(base_addr), .abort(abort), .feed_valid(a_feed_valid), .feed_addr(a_feed_addr),
        .feed_mask(a_feed_mask), .dp_clear(a_dp_clear), .dp_value(dp_value), .res_valid(a_res_valid),
        .res_ready(res_ready), .res_data(a_res_data), .busy(a_busy)
    );

    dot_product_sequencer #(.PIXEL_N(9)) dut_b (
        .clk(clk), .GlobalReset(GlobalReset), .start_valid(start_valid), .start_ready(b_start_ready),
        .base_addr(base_addr), .abort(abort), .feed_valid(b_feed_valid), .feed_addr(b_feed_addr),
        .feed_mask(b_feed_mask), .dp_clear(b_dp_clear), .dp_value(dp_value), .res_valid(b_res_valid),
        .res_ready(res_ready), .res_data(b_res_data), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lanes still owed on a beat: two while at least two remain, then whatever is left.
    function automatic logic [1:0] exp_mask(input int pix, input int beat);
        int left;
        left = pix - beat * 2;
        if (left >= 2) return 2'b11;
        if (left == 1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all(input string ph, input bit e_busy, input bit e_clear, input bit e_fv,
                             input bit chk_addr, input logic [7:0] e_addr,
                             input logic [1:0] e_mask_a, input logic [1:0] e_mask_b, input bit e_rv);
        check_eq({ph, " a.busy"}, 32'(a_busy), 32'(e_busy));
        check_eq({ph, " a.start_ready"}, 32'(a_start_ready), 32'(!e_busy));
        check_eq({ph, " a.dp_clear"}, 32'(a_dp_clear), 32'(e_clear));
        check_eq({ph, " a.feed_valid"}, 32'(a_feed_valid), 32'(e_fv));
        check_eq({ph, " a.feed_mask"}, 32'(a_feed_mask), 32'(e_mask_a));
        check_eq({ph, " a.res_valid"}, 32'(a_res_valid), 32'(e_rv));
        check_eq({ph, " a.res_data"}, 32'(a_res_data), 32'(exp_res));
        check_eq({ph, " b.busy"}, 32'(b_busy), 32'(e_busy));
        check_eq({ph, " b.start_ready"}, 32'(b_start_ready), 32'(!e_busy));
        check_eq({ph, " b.dp_clear"}, 32'(b_dp_clear), 32'(e_clear));
        check_eq({ph, " b.feed_valid"}, 32'(b_feed_valid), 32'(e_fv));
        check_eq({ph, " b.feed_mask"}, 32'(b_feed_mask), 32'(e_mask_b));
        check_eq({ph, " b.res_valid"}, 32'(b_res_valid), 32'(e_rv));
        check_eq({ph, " b.res_data"}, 32'(b_res_data), 32'(exp_res));
        if (chk_addr) begin
            check_eq({ph, " a.feed_addr"}, 32'(a_feed_addr), 32'(e_addr));
            check_eq({ph, " b.feed_addr"}, 32'(b_feed_addr), 32'(e_addr));
        end
    endtask

    // One transaction: start in cycle 0, result consumer stalls `hold` cycles,
    // optional abort in cycle abort_k, optional reset assertion in cycle rst_k (0 = none).
    task automatic run_op(input logic [7:0] base, input int hold, input int abort_k, input int rst_k);
        logic [25:0] dv [0:63];
        bit          aborted, e_busy, e_clear, e_fv, e_rv, in_done, last;
        logic [7:0]  e_addr;
        logic [1:0]  ma, mb;
        string       ph;
        op_id++;
        @(negedge clk);
        ph = $sformatf("op%0d k0", op_id);
        check_all(ph, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
        start_valid = 1'b1;
        base_addr   = base;
        abort       = 1'b0;
        res_ready   = 1'b0;
        dv[0]       = 26'($urandom);
        dp_value    = dv[0];
        for (int k = 1; k <= DONE_K + hold + 2; k++) begin
            @(negedge clk);
            ph      = $sformatf("op%0d k%0d", op_id, k);
            aborted = (abort_k > 0) && (k > abort_k);
            if (!aborted && k == DONE_K) exp_res = dv[DONE_K - 1];
            e_busy  = !aborted && (k <= DONE_K + hold);
            e_clear = (!aborted && k == 1) || (abort_k > 0 && k == abort_k + 1);
            e_fv    = !aborted && (k >= 2) && (k <= 1 + NF);
            e_rv    = !aborted && (k >= DONE_K) && (k <= DONE_K + hold);
            e_addr  = base + 8'(k - 2);
            ma      = e_fv ? exp_mask(10, k - 2) : 2'b00;
            mb      = e_fv ? exp_mask(9, k - 2) : 2'b00;
            check_all(ph, e_busy, e_clear, e_fv, e_fv, e_addr, ma, mb, e_rv);

            in_done     = (k >= DONE_K) && (k <= DONE_K + hold);
            start_valid = (k == abort_k);
            abort       = (k == abort_k);
            dv[k]       = 26'($urandom);
            dp_value    = dv[k];
            res_ready   = in_done ? ((k == DONE_K + hold) || (k == abort_k)) : 1'($urandom);
            last        = (abort_k > 0) ? (k == abort_k + 2) : (k == DONE_K + hold + 1);

            if (k == rst_k) begin
                GlobalReset = 1'b0;
                #1;
                exp_res = '0;
                check_all({ph, " rst"}, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 2'b00, 1'b0);
                @(negedge clk);
                GlobalReset = 1'b1;
                last        = 1'b1;
            end
            if (last) begin
                start_valid = 1'b0;
                abort       = 1'b0;
                res_ready   = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        GlobalReset = 1'b0;
        start_valid = 1'b0;
        base_addr   = 8'h00;
        abort       = 1'b0;
        dp_value    = '0;
        res_ready   = 1'b0;
        exp_res     = '0;
        #12;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        GlobalReset = 1'b1;

        run_op(8'h10, 0, 0, 0);                  // basic latency and addresses
        run_op(8'hFE, 3, 0, 0);                  // address wrap
        run_op(8'($urandom), 7, 0, 0);           // consumer stall in DONE
        run_op(8'($urandom), 0, 4, 0);           // abort on third FEED beat
        run_op(8'($urandom), 2, DONE_K - 1, 0);  // abort beats counter expiry
        run_op(8'($urandom), 8, DONE_K + 2, 0);  // abort beats res_ready

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

        run_op(8'($urandom), 2, 0, 10);          // reset during DRAIN
        run_op(8'($urandom), 1, 0, 0);           // clean run after reset
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), int'($urandom_range(0, 3)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Controller that runs one complete dot product on the PARALLEL-lane fixed-point dot-product datapath per request. It accepts a start command with a base address and clears the datapath accumulators. It then issues pixel/weight fetch beats to the operand memory, waits for the multiplier/adder pipeline to drain, and captures the summed value. The result is held on a valid/ready output. It sits between the layer-level scheduler and one dot-product datapath instance.

## Interface
- PIXEL_N, 10, pixel/weight pairs per dot product (≥1)
- PARALLEL, 2, lanes consumed per feed beat
- FPM_DELAY, 6, multiplier pipeline latency (cycles)
- FPA_DELAY, 2, adder pipeline latency (cycles)
- VAL_SIZE, 26, result width
- ADDR_W, 8, operand-memory beat address width

Ports:
- clk  in  1  single clock, rising edge
- GlobalReset  in  1  asynchronous, active-low reset
- start_valid  in  1  request a dot product
- start_ready  out  1  high only in IDLE
- base_addr  in  ADDR_W  first beat address; sampled at start handshake
- abort  in  1  cancel current operation
- feed_valid  out  1  operand beat is being issued this cycle
- feed_addr  out  ADDR_W  beat address
- feed_mask  out  PARALLEL  per-lane valid; memory returns zero for masked lanes
- dp_clear  out  1  active-high clear to the datapath reset input
- dp_value  in  VAL_SIZE  datapath summed output
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  VAL_SIZE  captured result
- busy  out  1  state ≠ IDLE

## Operation
- Derived constants:
  - N_FEED = ceil(PIXEL_N/PARALLEL).
  - REM = PIXEL_N − (N_FEED−1)·PARALLEL.
  - DRAIN = FPM_DELAY + FPA_DELAY + 4.
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE:
  - start_ready=1.
  - start_valid&start_ready: latch base_addr into the address register; go to CLEAR.
- CLEAR: dp_clear=1 for exactly one cycle; load beat counter with N_FEED−1; go to FEED.
- FEED:
  - feed_valid=1.
  - feed_addr = latched base + beat index, computed modulo 2^ADDR_W (wraps silently).
  - feed_mask = all ones, except the final beat, which has the low REM bits set.
  - When the counter reaches 0, load it with DRAIN−1 and go to DRAIN.
- DRAIN:
  - feed_valid=0, feed_mask=0.
  - When the counter reaches 0, capture dp_value into res_data and go to DONE.
- DONE:
  - res_valid=1; res_data is stable.
  - res_ready sampled high: go to IDLE.
  - No same-cycle restart. start_ready rises the cycle after the result handshake.
- abort:
  - In any state other than IDLE, abort moves to IDLE on the next edge, and dp_clear=1 in the cycle after the abort edge.
  - Abort has priority over res_ready and over counter expiry.
  - No result is produced. res_data keeps its old value and res_valid drops.
  - abort in IDLE is ignored.
  - A start_valid presented in the same cycle as an abort is not accepted.
- start_valid while busy: ignored, since start_ready=0.
- Reset values (GlobalReset=0, async):
  - state=IDLE.
  - start_ready=1 once the reset is released.
  - busy=0, feed_valid=0, feed_addr=0, feed_mask=0, dp_clear=0, res_valid=0, res_data=0.
  - Internal counter=0.
  - Reset mid-operation discards all state.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Start accepted at edge T:
  - CLEAR cycle T+1.
  - FEED cycles T+2 … T+1+N_FEED.
  - DRAIN cycles follow, DRAIN cycles long.
  - res_valid rises at T+2+N_FEED+DRAIN.
- Each feed_addr reaches the datapath operand registers one cycle after feed_valid, which is the memory latency. DRAIN covers the operand register, FPM, the adder input register, FPA and the sum register.
- res_data is sampled on the edge leaving the last DRAIN cycle.

## Structure
- Package dp_ctrl_pkg holds:
  - the state encoding (IDLE, CLEAR, FEED, DRAIN, DONE);
  - the ceil-div and CLOG2 helpers;
  - the DRAIN constant function of FPM_DELAY/FPA_DELAY.
- One sub-module, dp_seq_counter: a loadable down-counter with a zero flag. It is shared by FEED and DRAIN; its width is CLOG2(max(N_FEED, DRAIN))+1.
- The address register and the mask decode live in the top module.

## Test plan
- PIXEL_N=10, PARALLEL=2, base_addr=8'h10, start at T:
  - dp_clear at T+1.
  - feed_addr 10,11,12,13,14 at T+2..T+6, mask 2'b11 throughout.
  - res_valid at T+19; res_data equals the dp_value stub at T+18.
- PIXEL_N=9, PARALLEL=2 → five beats; the last beat has feed_mask=2'b01. Check res_valid timing.
- base_addr=8'hFE, PIXEL_N=10 → feed_addr FE, FF, 00, 01, 02.
- Hold res_ready=0 for 7 cycles in DONE:
  - res_valid and res_data stay stable and start_ready stays 0.
  - After res_ready=1, start_ready=1 on the next cycle.
- Assert abort on the third FEED beat:
  - IDLE on the next edge, with dp_clear=1 in the following cycle.
  - No res_valid; a start_valid in the abort cycle is not accepted.
- Drive GlobalReset low during DRAIN: all outputs take their reset values immediately. After release, a new start completes normally with the T+19 latency.
